rcc_sys_clk_sw_ctrl: RTL
========================

RCC_SYS_CLK_SW_CTRL -- requirements
Module: rcc_sys_clk_sw_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096, SHALL set the maximum number of cycles spent waiting for target oscillator ready.
REQ-002 Parameter SETTLE_CYC, default 4, SHALL set the cycles between driving sys_clk_sw and reporting sws (glitch-free switch handover time); legal range 1..15.
REQ-003 Ports, one per line:
- clk_in  in  1  controller clock (always-on HSI domain)
- rst_n  in  1  asynchronous, active-low reset
- sw_wr  in  1  single-cycle software write strobe of SW field
- sw_req  in  2  requested source: 00 HSI, 01 CSI, 10 HSE, 11 PLL1_P
- osc_rdy  in  4  ready flags {pll1, hse, csi, hsi}, synchronous to clk_in
- stop_exit  in  1  single-cycle pulse on wake-up from system stop
- stopwuck  in  1  wake-up source select: 0 HSI, 1 CSI
- hse_css_fail  in  1  HSE clock-security failure level
- err_clr  in  1  single-cycle clear of sticky flags
- sys_clk_sw  out  2  select to glitch-free sys_clk mux, registered
- sws  out  2  reported active source, registered
- sw_busy  out  1  switch sequence in progress
- sw_timeout_err  out  1  sticky: target never became ready
- css_flag  out  1  sticky: HSE failure forced HSI

Function
REQ-010 FSM states SHALL be IDLE, WAIT_RDY, SWITCH, SETTLE.
REQ-011 IDLE: sw_wr with sw_req != sys_clk_sw SHALL latch target<=sw_req, load timeout counter, set sw_busy, go WAIT_RDY; sw_wr with sw_req == sys_clk_sw SHALL be ignored.
REQ-012 WAIT_RDY: osc_rdy[target]=1 SHALL go SWITCH next cycle; otherwise counter decrements each cycle.
REQ-013 WAIT_RDY timeout: counter reaching 0 after TIMEOUT_CYC cycles SHALL set sw_timeout_err, clear sw_busy, return IDLE, leave sys_clk_sw and sws unchanged.
REQ-014 SWITCH: one cycle; sys_clk_sw<=target registered on exit; settle counter loaded SETTLE_CYC; go SETTLE.
REQ-015 SETTLE: counter decrements; on reaching 0 sws<=target, sw_busy<=0, go IDLE; ready-to-sws latency = SETTLE_CYC+2 cycles.
REQ-016 sw_wr while sw_busy=1 SHALL be ignored (no queuing).
REQ-017 stop_exit SHALL, from any state, set target = stopwuck ? 01 : 00, reload timeout counter, set sw_busy, go WAIT_RDY in the next cycle, aborting any sequence.
REQ-018 Priority on simultaneous events: hse_css_fail > stop_exit > sw_wr.
REQ-019 sys_clk_sw SHALL change only on SWITCH exit (or reset); sws SHALL change only on SETTLE completion (or reset).
REQ-020 Osc ready dropping for the active source outside CSS SHALL not alter state.
REQ-021 err_clr SHALL clear sw_timeout_err and css_flag; a same-cycle set SHALL win over clear.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, sys_clk_sw=00, sws=00, sw_busy=0, sw_timeout_err=0, css_flag=0, counters 0, target=00.
REQ-031 Reset deassertion mid-sequence SHALL restart in IDLE with HSI selected; no sequence resumes.

Configuration
REQ-040 Macro RCC_SYS_CLK_CSS_EN defined: hse_css_fail high while sys_clk_sw==10 or target==10 SHALL set css_flag, force target=00, go WAIT_RDY, set sw_busy, from any state.
REQ-041 Macro undefined: hse_css_fail SHALL be ignored, css_flag SHALL be constant 0, REQ-018 reduces to stop_exit > sw_wr.

Verification
REQ-050 Reset, osc_rdy=0001, sw_wr sw_req=11, pll1 ready 10 cycles later -> sys_clk_sw=11 two cycles after ready, sws=11 and sw_busy=0 after SETTLE_CYC+2 total.
REQ-051 sw_wr sw_req=10, osc_rdy[2] held 0 -> after 4096 cycles sw_timeout_err=1, sw_busy=0, sys_clk_sw=00; err_clr -> flag 0.
REQ-052 sws=11, stop_exit with stopwuck=1, osc_rdy=0011 -> sys_clk_sw=01, sws=01; a concurrent sw_wr=10 is ignored.
REQ-053 With RCC_SYS_CLK_CSS_EN, sws=10, hse_css_fail=1 -> css_flag=1, sys_clk_sw=00, sws=00; without macro -> no change, css_flag=0.
REQ-054 sw_wr sw_req=00 while sws=00 -> sw_busy stays 0, no output toggles; rst_n low during SETTLE -> all outputs 00/0 immediately.

Source files
------------

// File: rtl/rcc_sys_clk_sw_ctrl.sv
// System clock source switch sequencer: waits for target oscillator ready, drives the
// glitch-free mux select, then reports the new source after a settle time.
// Define RCC_SYS_CLK_CSS_EN to enable HSE clock-security fallback to HSI.
module rcc_sys_clk_sw_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned SETTLE_CYC  = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       sw_wr,
  input  logic [1:0] sw_req,
  input  logic [3:0] osc_rdy,
  input  logic       stop_exit,
  input  logic       stopwuck,
  input  logic       hse_css_fail,
  input  logic       err_clr,
  output logic [1:0] sys_clk_sw,
  output logic [1:0] sws,
  output logic       sw_busy,
  output logic       sw_timeout_err,
  output logic       css_flag
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] SrcHsi = 2'b00;
  localparam logic [1:0] SrcCsi = 2'b01;
  localparam logic [1:0] SrcHse = 2'b10;

  typedef enum logic [1:0] {StIdle, StWaitRdy, StSwitch, StSettle} state_e;

  state_e        state;
  logic [1:0]    target;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    settle_cnt;

  logic css_evt;
  logic stop_evt;
  logic tgt_rdy;
  logic tmo_set;

  assign tgt_rdy  = osc_rdy[target];
  assign stop_evt = stop_exit;

`ifdef RCC_SYS_CLK_CSS_EN
  // Once a fallback to HSI is in flight, a still-high failure level must not restart it.
  assign css_evt = hse_css_fail && (target == SrcHse || sys_clk_sw == SrcHse) &&
                   !(state != StIdle && target == SrcHsi);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      css_flag <= 1'b0;
    end else if (css_evt) begin
      css_flag <= 1'b1;
    end else if (err_clr) begin
      css_flag <= 1'b0;
    end
  end
`else
  logic unused_css_fail;
  assign unused_css_fail = hse_css_fail;
  assign css_evt         = 1'b0;
  assign css_flag        = 1'b0;
`endif

  assign tmo_set = (state == StWaitRdy) && !tgt_rdy && (tmo_cnt <= TW'(1)) &&
                   !css_evt && !stop_evt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      target         <= SrcHsi;
      tmo_cnt        <= '0;
      settle_cnt     <= '0;
      sys_clk_sw     <= SrcHsi;
      sws            <= SrcHsi;
      sw_busy        <= 1'b0;
      sw_timeout_err <= 1'b0;
    end else begin
      if (tmo_set) begin
        sw_timeout_err <= 1'b1;
      end else if (err_clr) begin
        sw_timeout_err <= 1'b0;
      end

      if (css_evt || stop_evt) begin
        // Forced re-targeting aborts whatever sequence is running.
        target     <= css_evt ? SrcHsi : (stopwuck ? SrcCsi : SrcHsi);
        tmo_cnt    <= TW'(TIMEOUT_CYC);
        settle_cnt <= '0;
        sw_busy    <= 1'b1;
        state      <= StWaitRdy;
      end else begin
        unique case (state)
          StIdle: begin
            if (sw_wr && (sw_req != sys_clk_sw)) begin
              target  <= sw_req;
              tmo_cnt <= TW'(TIMEOUT_CYC);
              sw_busy <= 1'b1;
              state   <= StWaitRdy;
            end
          end
          StWaitRdy: begin
            if (tgt_rdy) begin
              state <= StSwitch;
            end else if (tmo_cnt <= TW'(1)) begin
              // Give up; the mux keeps its current source.
              tmo_cnt <= '0;
              target  <= sys_clk_sw;
              sw_busy <= 1'b0;
              state   <= StIdle;
            end else begin
              tmo_cnt <= tmo_cnt - TW'(1);
            end
          end
          StSwitch: begin
            sys_clk_sw <= target;
            settle_cnt <= 4'(SETTLE_CYC);
            tmo_cnt    <= '0;
            state      <= StSettle;
          end
          StSettle: begin
            if (settle_cnt <= 4'd1) begin
              settle_cnt <= '0;
              sws        <= target;
              sw_busy    <= 1'b0;
              state      <= StIdle;
            end else begin
              settle_cnt <= settle_cnt - 4'd1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
